// File: rtl/pps_chk.sv
// PPS input checker: synchronises an asynchronous 1PPS input, measures each period in clock
// cycles and tracks lock / loss-of-signal with a saturating error counter.
module pps_chk #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned CNT_W      = 28
) (
  input  logic             clk100MHz,
  input  logic             areset,
  input  logic             PPS_IN,
  input  logic             clear_err,
  output logic             pps_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ok,
  output logic             locked,
  output logic             los,
  output logic [15:0]      err_count
);

  localparam int unsigned RunW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(CLK_FREQ + TOL);
  localparam logic [CNT_W:0]   PerMin     = (CNT_W + 1)'(CLK_FREQ - TOL);
  localparam logic [CNT_W:0]   PerMax     = (CNT_W + 1)'(CLK_FREQ + TOL);

  typedef enum logic [1:0] {
    StNoSignal,
    StAcquire,
    StLocked
  } state_e;

  // Synchroniser, edge detect and outputs
  logic             r_sync1, r_sync2, r_sync3;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_ok;
  logic             r_locked;
  logic             r_los;
  logic [15:0]      r_err_count;

  // FSM state
  state_e           r_state;
  logic [RunW-1:0]  r_good_run;
  logic             r_have_ref;

  state_e           w_state_next;
  logic [RunW-1:0]  w_good_run_next;
  logic             w_have_ref_next;

  logic             w_edge;
  logic             w_meas;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_good;
  logic             w_timeout;
  logic             w_err_evt;
  logic [RunW-1:0]  w_run_inc;

  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_meas    = w_edge & r_have_ref;
  // One extra bit so the all-ones count cannot wrap into the good window
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_good    = (w_cnt_inc >= PerMin) && (w_cnt_inc <= PerMax);
  // A coincident edge wins over the timeout
  assign w_timeout = r_have_ref && !w_edge && (r_cnt == CntTimeout);
  assign w_err_evt = (w_meas && !w_good) || w_timeout;
  assign w_run_inc = r_good_run + RunW'(1);

  always_ff @(posedge clk100MHz) begin
    if (areset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= PPS_IN;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= w_edge;
      if (w_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != CntMax) begin
        r_cnt <= w_cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (areset) begin
      r_period <= '0;
      r_valid  <= 1'b0;
      r_ok     <= 1'b0;
    end else begin
      r_valid <= w_meas;
      if (w_meas) begin
        r_period <= w_cnt_inc[CNT_W-1:0];
        r_ok     <= w_good;
      end
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (areset) begin
      r_err_count <= '0;
    end else if (clear_err) begin
      r_err_count <= {15'd0, w_err_evt};
    end else if (w_err_evt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (areset) begin
      r_state    <= StNoSignal;
      r_good_run <= '0;
      r_have_ref <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good_run <= w_good_run_next;
      r_have_ref <= w_have_ref_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_good_run_next = r_good_run;
    w_have_ref_next = r_have_ref;
    if (w_timeout) begin
      w_state_next    = StNoSignal;
      w_good_run_next = '0;
      w_have_ref_next = 1'b0;
    end else if (w_edge) begin
      unique case (r_state)
        StNoSignal: begin
          w_state_next    = StAcquire;
          w_good_run_next = '0;
          w_have_ref_next = 1'b1;
        end
        StAcquire: begin
          if (w_good) begin
            w_good_run_next = w_run_inc;
            if (w_run_inc == RunW'(LOCK_COUNT)) begin
              w_state_next = StLocked;
            end
          end else begin
            w_good_run_next = '0;
          end
        end
        StLocked: begin
          if (!w_good) begin
            w_state_next    = StAcquire;
            w_good_run_next = '0;
          end
        end
        default: begin
          w_state_next    = StNoSignal;
          w_good_run_next = '0;
          w_have_ref_next = 1'b0;
        end
      endcase
    end
  end

  // Status flags lag the state register by one cycle
  always_ff @(posedge clk100MHz) begin
    if (areset) begin
      r_locked <= 1'b0;
      r_los    <= 1'b1;
    end else begin
      r_locked <= (r_state == StLocked);
      r_los    <= (r_state == StNoSignal);
    end
  end

  assign pps_pulse    = r_pulse;
  assign period       = r_period;
  assign period_valid = r_valid;
  assign period_ok    = r_ok;
  assign locked       = r_locked;
  assign los          = r_los;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_pps_chk.sv
// Directed bench for pps_chk with CLK_FREQ=1000, TOL=2, LOCK_COUNT=3, CNT_W=12.
module tb_pps_chk;

  logic        clk100MHz;
  logic        areset;
  logic        PPS_IN;
  logic        clear_err;
  logic        pps_pulse;
  logic [11:0] period;
  logic        period_valid;
  logic        period_ok;
  logic        locked;
  logic        los;
  logic [15:0] err_count;

  int n_total = 0;
  int n_bad   = 0;
  int since_raise = 0;
  int n_pulse = 0;

  logic        s_pre, s_pulse, s_valid, s_ok, s_locked0, s_los0, s_locked, s_los;
  logic [31:0] s_period, s_err;

  pps_chk #(
    .CLK_FREQ  (1000),
    .TOL       (2),
    .LOCK_COUNT(3),
    .CNT_W     (12)
  ) dut (
    .clk100MHz   (clk100MHz),
    .areset      (areset),
    .PPS_IN      (PPS_IN),
    .clear_err   (clear_err),
    .pps_pulse   (pps_pulse),
    .period      (period),
    .period_valid(period_valid),
    .period_ok   (period_ok),
    .locked      (locked),
    .los         (los),
    .err_count   (err_count)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk100MHz);
    #1;
    since_raise++;
    if (since_raise == 100) PPS_IN = 1'b0;
    if (pps_pulse) n_pulse++;
  endtask

  task automatic tick_to(input int t);
    while (since_raise < t) tick();
  endtask

  // Raise PPS_IN 'gap' cycles after the previous rise; sample the pulse cycle and the one after
  task automatic pps_edge(input int gap, input logic clr);
    tick_to(gap);
    PPS_IN      = 1'b1;
    since_raise = 0;
    n_pulse     = 0;
    tick();
    tick();
    s_pre = pps_pulse;
    if (clr) clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    s_pulse   = pps_pulse;
    s_valid   = period_valid;
    s_period  = 32'(period);
    s_ok      = period_ok;
    s_err     = 32'(err_count);
    s_locked0 = locked;
    s_los0    = los;
    tick();
    s_locked  = locked;
    s_los     = los;
  endtask

  initial begin
    areset    = 1'b1;
    PPS_IN    = 1'b0;
    clear_err = 1'b0;
    tick();
    tick();
    tick();
    check("rst_pulse", 32'(pps_pulse), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_ok", 32'(period_ok), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_los", 32'(los), 32'd1);
    check("rst_err", 32'(err_count), 32'd0);
    areset = 1'b0;
    since_raise = 0;

    // First edge only establishes the reference
    pps_edge(200, 1'b0);
    check("first_pre", 32'(s_pre), 32'd0);
    check("first_pulse", 32'(s_pulse), 32'd1);
    check("first_valid", 32'(s_valid), 32'd0);
    check("first_los_same", 32'(s_los0), 32'd1);
    check("first_los_after", 32'(s_los), 32'd0);
    tick_to(999);
    check("one_pulse_per_high", n_pulse, 32'd1);

    for (int i = 0; i < 3; i++) begin
      pps_edge(1000, 1'b0);
      check("lock_valid", 32'(s_valid), 32'd1);
      check("lock_period", s_period, 32'd1000);
      check("lock_ok", 32'(s_ok), 32'd1);
      check("lock_err", s_err, 32'd0);
      check("lock_locked0", 32'(s_locked0), 32'd0);
      check("lock_locked", 32'(s_locked), (i == 2) ? 32'd1 : 32'd0);
    end

    // Interval 1003: edge coincides with timeout count, edge wins
    pps_edge(1003, 1'b0);
    check("long_valid", 32'(s_valid), 32'd1);
    check("long_period", s_period, 32'd1003);
    check("long_ok", 32'(s_ok), 32'd0);
    check("long_err", s_err, 32'd1);
    check("long_locked0", 32'(s_locked0), 32'd1);
    check("long_locked", 32'(s_locked), 32'd0);
    check("long_los", 32'(s_los), 32'd0);
    tick();
    check("long_los_later", 32'(los), 32'd0);

    for (int i = 0; i < 3; i++) begin
      pps_edge(998, 1'b0);
      check("relock_period", s_period, 32'd998);
      check("relock_ok", 32'(s_ok), 32'd1);
      check("relock_locked", 32'(s_locked), (i == 2) ? 32'd1 : 32'd0);
    end
    check("relock_err", s_err, 32'd1);

    // Signal stops: timeout lands when the count reaches 1002
    tick_to(1005);
    check("to_err_before", 32'(err_count), 32'd1);
    check("to_locked_before", 32'(locked), 32'd1);
    tick();
    check("to_err", 32'(err_count), 32'd2);
    check("to_los_same", 32'(los), 32'd0);
    tick();
    check("to_los", 32'(los), 32'd1);
    check("to_locked", 32'(locked), 32'd0);
    tick_to(2500);
    check("to_err_once", 32'(err_count), 32'd2);
    check("to_los_held", 32'(los), 32'd1);

    pps_edge(2600, 1'b0);
    check("resume_pulse", 32'(s_pulse), 32'd1);
    check("resume_valid", 32'(s_valid), 32'd0);
    check("resume_los", 32'(s_los), 32'd0);
    pps_edge(1000, 1'b0);
    check("resume2_valid", 32'(s_valid), 32'd1);
    check("resume2_period", s_period, 32'd1000);
    check("resume2_ok", 32'(s_ok), 32'd1);
    check("resume2_err", s_err, 32'd2);

    // Preload the counter near saturation
    force dut.r_err_count = 16'hFFFE;
    #1;
    release dut.r_err_count;
    pps_edge(997, 1'b0);
    check("sat_period", s_period, 32'd997);
    check("sat_ok", 32'(s_ok), 32'd0);
    check("sat_err1", s_err, 32'hFFFF);
    pps_edge(1003, 1'b0);
    check("sat_err2", s_err, 32'hFFFF);
    tick_to(20);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_alone", 32'(err_count), 32'd0);
    pps_edge(1002, 1'b0);
    check("upper_ok", 32'(s_ok), 32'd1);
    check("upper_err", s_err, 32'd0);
    pps_edge(997, 1'b1);
    check("clear_evt_ok", 32'(s_ok), 32'd0);
    check("clear_evt_err", s_err, 32'd1);

    for (int i = 0; i < 3; i++) pps_edge(1000, 1'b0);
    check("pre_rst_locked", 32'(s_locked), 32'd1);

    // Reset mid-interval while locked
    tick_to(400);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("mrst_pulse", 32'(pps_pulse), 32'd0);
    check("mrst_valid", 32'(period_valid), 32'd0);
    check("mrst_period", 32'(period), 32'd0);
    check("mrst_ok", 32'(period_ok), 32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_los", 32'(los), 32'd1);
    check("mrst_err", 32'(err_count), 32'd0);
    pps_edge(1000, 1'b0);
    check("mrst_first_pulse", 32'(s_pulse), 32'd1);
    check("mrst_first_valid", 32'(s_valid), 32'd0);
    check("mrst_first_period", s_period, 32'd0);
    for (int i = 0; i < 3; i++) begin
      pps_edge(1000, 1'b0);
      check("mrst_period", s_period, 32'd1000);
      check("mrst_relock", 32'(s_locked), (i == 2) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
